fifo_rd_packer: RTL and testbench

- Read-side consumer for the dual-clock FIFO; lives entirely in the rclk domain.
- Pops bytes from the FIFO read port (rinc/rdata/rempty) and packs PACK consecutive bytes into one wide word.
- Presents each word downstream on a valid/ready handshake.
- Partial words are emitted on idle timeout or explicit flush.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_rd_packer_idle_timer.sv | 20 ++
 rtl/fifo_rd_packer.sv | 103 ++++++++++
 tb/tb_fifo_rd_packer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read-side packer.
package fifo_pkg;
  typedef enum logic {FILL, OUT} state_t;

  localparam int FIFO_DATAWIDTH  = 8;
  localparam int FIFO_PACK       = 4;
  localparam int FIFO_RD_TIMEOUT = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_rd_packer_idle_timer.sv
// Idle timer: counts enabled cycles, pulses expire on the TIMEOUT-th one.
module rd_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic rclk,
  input  logic rrst,
  input  logic clear,
  input  logic en,
  output logic expire
);
  logic [7:0] cnt;

  assign expire = en && !clear && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge rclk) begin
    if (rrst)                cnt <= '0;
    else if (clear || expire) cnt <= '0;
    else if (en)             cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries, packs PACK of them per word, emits on full/timeout/flush.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH = FIFO_DATAWIDTH,
  parameter int PACK      = FIFO_PACK,
  parameter int TIMEOUT   = FIFO_RD_TIMEOUT
) (
  input  logic                      rclk,
  input  logic                      rrst,
  input  logic [DATAWIDTH-1:0]      rdata,
  input  logic                      rempty,
  output logic                      rinc,
  input  logic                      flush,
  output logic [PACK*DATAWIDTH-1:0] m_data,
  output logic [PACK-1:0]           m_keep,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [15:0]               word_cnt
);
  localparam int IW = clog2(PACK);

  state_t                         state;
  logic [IW-1:0]                  idx;
  logic [PACK-1:0][DATAWIDTH-1:0] acc, acc_nxt, data_q;
  logic [PACK-1:0]                keep, keep_nxt;
  logic                           pop, last, t_en, t_clr, expire;

  assign rinc   = (state == FILL) && !rempty && !rrst;
  assign pop    = rinc;
  assign last   = (idx == IW'(PACK - 1));
  assign m_data = data_q;

  // Counting only while a partial word waits on an empty FIFO.
  assign t_en  = (state == FILL) && !pop && (idx != '0);
  assign t_clr = !t_en;

  rd_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .rclk   (rclk),
    .rrst   (rrst),
    .clear  (t_clr),
    .en     (t_en),
    .expire (expire)
  );

  always_comb begin
    acc_nxt  = acc;
    keep_nxt = keep;
    if (pop) begin
      acc_nxt[idx]  = rdata;
      keep_nxt[idx] = 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state    <= FILL;
      idx      <= '0;
      acc      <= '0;
      keep     <= '0;
      data_q   <= '0;
      m_keep   <= '0;
      m_valid  <= 1'b0;
      word_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (pop) begin
            acc  <= acc_nxt;
            keep <= keep_nxt;
            // A flush on the completing pop is just a normal full emit.
            if (last || flush) begin
              data_q  <= acc_nxt;
              m_keep  <= keep_nxt;
              m_valid <= 1'b1;
              idx     <= '0;
              state   <= OUT;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if ((idx != '0) && (flush || expire)) begin
            data_q  <= acc;
            m_keep  <= keep;
            m_valid <= 1'b1;
            idx     <= '0;
            state   <= OUT;
          end
        end
        OUT: begin
          if (m_valid && m_ready) begin
            m_valid  <= 1'b0;
            m_keep   <= '0;
            acc      <= '0;
            keep     <= '0;
            word_cnt <= word_cnt + 16'd1;
            state    <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench: behavioural FIFO front end, hand-computed packed words.
module tb_fifo_rd_packer;
  logic        rclk = 1'b0;
  logic        rrst;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic        flush;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] word_cnt;

  logic [7:0] q[$];
  int passed = 0;
  int total  = 0;
  int pops   = 0;
  int exp_cnt = 0;

  always #5 rclk = ~rclk;

  fifo_rd_packer dut (
    .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .flush(flush), .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid),
    .m_ready(m_ready), .word_cnt(word_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic refresh();
    rempty = (q.size() == 0);
    rdata  = rempty ? 8'h00 : q[0];
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    refresh();
  endtask

  // One clock: sample rinc mid-cycle, pop the model FIFO after the edge.
  task automatic tick();
    logic p;
    @(negedge rclk);
    p = rinc;
    @(posedge rclk);
    #1;
    if (p) begin
      void'(q.pop_front());
      pops++;
    end
    refresh();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rrst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    refresh();
    ticks(2);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_keep", {28'd0, m_keep}, 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_cnt", {16'd0, word_cnt}, 32'd0);
    chk("rst_rinc", {31'd0, rinc}, 32'd0);
    rrst = 1'b0;

    // Full word
    m_ready = 1'b1; pops = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    ticks(4);
    chk("full_pops", pops, 4);
    chk("full_valid", {31'd0, m_valid}, 32'd1);
    chk("full_data", m_data, 32'h44332211);
    chk("full_keep", {28'd0, m_keep}, 32'hF);
    tick(); exp_cnt++;
    chk("full_drop", {31'd0, m_valid}, 32'd0);
    chk("full_cnt", {16'd0, word_cnt}, exp_cnt);
    ticks(2);
    chk("full_nopop", pops, 4);

    // Backpressure
    m_ready = 1'b0; pops = 0;
    for (int i = 0; i < 8; i++) push(8'(i));
    ticks(4);
    chk("bp_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_data", m_data, 32'h03020100);
    ticks(16);
    chk("bp_pops", pops, 4);
    chk("bp_rinc", {31'd0, rinc}, 32'd0);
    chk("bp_hold", m_data, 32'h03020100);
    chk("bp_hold_v", {31'd0, m_valid}, 32'd1);
    m_ready = 1'b1;
    tick(); exp_cnt++;
    chk("bp_cnt1", {16'd0, word_cnt}, exp_cnt);
    ticks(4);
    chk("bp_data2", m_data, 32'h07060504);
    chk("bp_keep2", {28'd0, m_keep}, 32'hF);
    tick(); exp_cnt++;
    chk("bp_cnt2", {16'd0, word_cnt}, exp_cnt);

    // Timeout
    m_ready = 1'b0;
    push(8'hA1); push(8'hA2);
    ticks(2);
    ticks(14);
    chk("to_early", {31'd0, m_valid}, 32'd0);
    ticks(2);
    chk("to_valid", {31'd0, m_valid}, 32'd1);
    chk("to_data", m_data, 32'h0000A2A1);
    chk("to_keep", {28'd0, m_keep}, 32'h3);
    m_ready = 1'b1;
    tick(); exp_cnt++;
    chk("to_cnt", {16'd0, word_cnt}, exp_cnt);

    // Flush of a partial word
    m_ready = 1'b0;
    push(8'hB0); push(8'hB1); push(8'hB2);
    ticks(3);
    ticks(2);
    chk("fl_pre", {31'd0, m_valid}, 32'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_valid", {31'd0, m_valid}, 32'd1);
    chk("fl_keep", {28'd0, m_keep}, 32'h7);
    chk("fl_data", m_data, 32'h00B2B1B0);
    m_ready = 1'b1;
    tick(); exp_cnt++;
    chk("fl_cnt", {16'd0, word_cnt}, exp_cnt);
    flush = 1'b1; tick(); flush = 1'b0;
    ticks(3);
    chk("fl_idle_v", {31'd0, m_valid}, 32'd0);
    chk("fl_idle_cnt", {16'd0, word_cnt}, exp_cnt);

    // Flush on the completing pop
    m_ready = 1'b0;
    push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
    ticks(3);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flc_valid", {31'd0, m_valid}, 32'd1);
    chk("flc_keep", {28'd0, m_keep}, 32'hF);
    chk("flc_data", m_data, 32'hC3C2C1C0);
    m_ready = 1'b1;
    tick(); exp_cnt++;
    ticks(3);
    chk("flc_cnt", {16'd0, word_cnt}, exp_cnt);
    chk("flc_noextra", {31'd0, m_valid}, 32'd0);

    // Mid-operation reset
    pops = 0;
    for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
    ticks(2);
    rrst = 1'b1; #1;
    chk("mr_rinc", {31'd0, rinc}, 32'd0);
    tick();
    chk("mr_valid", {31'd0, m_valid}, 32'd0);
    chk("mr_cnt", {16'd0, word_cnt}, 32'd0);
    chk("mr_pops", pops, 2);
    rrst = 1'b0; exp_cnt = 0;
    ticks(4);
    chk("mr_data", m_data, 32'hD5D4D3D2);
    chk("mr_keep", {28'd0, m_keep}, 32'hF);
    tick(); exp_cnt++;
    chk("mr_cnt2", {16'd0, word_cnt}, exp_cnt);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
